io_responder: RTL and testbench



---
 rtl/io_pkg.sv | 29 ++
 rtl/button_debounce.sv | 102 ++++++++++
 rtl/io_responder.sv | 98 +++++++++
 tb/tb_io_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Service codes and debounce state encoding shared by the CPU
//               I/O path (responder and routing block).
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam logic [2:0] SEL_CONFIRM  = 3'd0;
    localparam logic [2:0] SEL_DATA     = 3'd1;
    localparam logic [2:0] SEL_INDEX    = 3'd2;
    localparam logic [2:0] SEL_DATA_ALT = 3'd3;
    localparam logic [2:0] SEL_LED      = 3'd4;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_t;

    // Both data service codes consume the pending confirm flag.
    function automatic logic is_data_sel(input logic [2:0] s);
        return (s == SEL_DATA) || (s == SEL_DATA_ALT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : 2-flop synchronizer plus press/release debounce FSM; emits a
//               single accept pulse per debounced press and a debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_accept,
    output logic o_level
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_btn;
    logic             w_at_last;
    logic             w_accept;

    assign w_btn     = r_sync[1];
    assign w_at_last = (r_cnt == C_CNT_LAST);
    // Saturating increment: the counter never wraps back to zero.
    assign w_cnt_inc = w_at_last ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (w_btn) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_btn) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (w_at_last) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_PRESSED: begin
                if (!w_btn) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // A bounce back to 1 resumes the press without a new accept.
                if (w_btn) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (w_at_last) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_accept = w_accept;
    assign o_level  = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);

endmodule
`default_nettype wire

// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_responder
// Description : Peripheral end of the CPU I/O path: snapshots switches on each
//               debounced confirm press, exposes a pollable flag, drives LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module io_responder
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_read,
    input  logic        io_write,
    input  logic        led_ctrl,
    input  logic [2:0]  sel,
    input  logic [31:0] wdata,
    input  logic [7:0]  switch_in,
    input  logic [2:0]  index_sw,
    input  logic        confirm_btn,
    output logic [7:0]  io_rdata,
    output logic        confirm_flag,
    output logic [2:0]  test_index,
    output logic [15:0] led_out
);

    logic [7:0]  r_sw_s1;
    logic [7:0]  r_sw_s2;
    logic [2:0]  r_idx_s1;
    logic [2:0]  r_idx_s2;
    logic [7:0]  r_data_latch;
    logic [2:0]  r_index_latch;
    logic        r_flag;
    logic [15:0] r_led;
    logic        w_accept;
    logic        w_btn_level;
    logic        w_unused;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (confirm_btn),
        .o_accept (w_accept),
        .o_level  (w_btn_level)
    );

    assign w_unused = ^{wdata[31:16], w_btn_level};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_s1  <= 8'h00;
            r_sw_s2  <= 8'h00;
            r_idx_s1 <= 3'b000;
            r_idx_s2 <= 3'b000;
        end else begin
            r_sw_s1  <= switch_in;
            r_sw_s2  <= r_sw_s1;
            r_idx_s1 <= index_sw;
            r_idx_s2 <= r_idx_s1;
        end
    end

    // Accept has priority over a same-cycle data read clearing the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_latch  <= 8'h00;
            r_index_latch <= 3'b000;
            r_flag        <= 1'b0;
        end else if (w_accept) begin
            r_data_latch  <= r_sw_s2;
            r_index_latch <= r_idx_s2;
            r_flag        <= 1'b1;
        end else if (io_read && is_data_sel(sel)) begin
            r_flag        <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= 16'h0000;
        end else if (io_write && led_ctrl && (sel == SEL_LED)) begin
            r_led <= wdata[15:0];
        end
    end

    assign io_rdata     = r_data_latch;
    assign test_index   = r_index_latch;
    assign confirm_flag = r_flag;
    assign led_out      = r_led;

endmodule
`default_nettype wire

// File: tb/tb_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_responder
// Description : Self-checking bench for io_responder (DEBOUNCE_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_responder;
    import io_pkg::*;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_read = 1'b0;
    logic        io_write = 1'b0;
    logic        led_ctrl = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [31:0] wdata = 32'h0;
    logic [7:0]  switch_in = 8'h00;
    logic [2:0]  index_sw = 3'd0;
    logic        confirm_btn = 1'b0;
    logic [7:0]  io_rdata;
    logic        confirm_flag;
    logic [2:0]  test_index;
    logic [15:0] led_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic [2:0] i;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        wr;
        logic        cs;
        logic [2:0]  s;
        logic [31:0] wd;
        logic [15:0] exp_led;
    } led_vec_t;

    typedef struct {
        logic [2:0] s;
        logic       exp_flag;
    } rd_vec_t;

    always #5 clk = ~clk;

    io_responder #(.DEBOUNCE_CYCLES(DEB)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .io_read      (io_read),
        .io_write     (io_write),
        .led_ctrl     (led_ctrl),
        .sel          (sel),
        .wdata        (wdata),
        .switch_in    (switch_in),
        .index_sw     (index_sw),
        .confirm_btn  (confirm_btn),
        .io_rdata     (io_rdata),
        .confirm_flag (confirm_flag),
        .test_index   (test_index),
        .led_out      (led_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_flag(output int n);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (confirm_flag) break;
        end
    endtask

    task automatic check_latency(input string name, input int n);
        checks++;
        if (n < 2 + DEB || n > 2 + DEB + 1) begin
            errors++;
            $display("FAIL %s: flag after %0d cycles, expected %0d..%0d", name, n, 2 + DEB, 2 + DEB + 1);
        end
    endtask

    // Scoreboard: every visible accept (flag rise or latch change) pops one entry.
    logic       p_flag = 1'b0;
    logic [7:0] p_d = 8'h00;
    logic [2:0] p_i = 3'd0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_flag = 1'b0;
            p_d    = 8'h00;
            p_i    = 3'd0;
        end else begin
            if ((confirm_flag && !p_flag) || (io_rdata !== p_d) || (test_index !== p_i)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got data 0x%0h index %0d, expected no accept", io_rdata, test_index);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", {24'h0, io_rdata}, {24'h0, e.d});
                    check("sb_index", {29'h0, test_index}, {29'h0, e.i});
                    check("sb_flag", {31'h0, confirm_flag}, 32'h1);
                end
            end
            p_flag = confirm_flag;
            p_d    = io_rdata;
            p_i    = test_index;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        led_vec_t   lv[6];
        rd_vec_t    rv[3];
        logic [15:0] prev_led;
        int         n;

        lv[0] = '{1'b1, 1'b1, SEL_LED, 32'hDEAD_BEEF, 16'hBEEF};
        lv[1] = '{1'b1, 1'b1, 3'd5,    32'h1234_5678, 16'hBEEF};
        lv[2] = '{1'b1, 1'b0, SEL_LED, 32'h1234_5678, 16'hBEEF};
        lv[3] = '{1'b0, 1'b1, SEL_LED, 32'h1234_5678, 16'hBEEF};
        lv[4] = '{1'b1, 1'b1, SEL_LED, 32'hFFFF_A5A5, 16'hA5A5};
        lv[5] = '{1'b1, 1'b1, SEL_CONFIRM, 32'hFFFF_FFFF, 16'hA5A5};
        rv[0] = '{SEL_CONFIRM, 1'b1};
        rv[1] = '{SEL_INDEX,   1'b1};
        rv[2] = '{SEL_DATA,    1'b0};

        // Reset with switches set and button held
        switch_in   = 8'hA5;
        index_sw    = 3'd2;
        confirm_btn = 1'b1;
        ticks(3);
        @(negedge clk);
        check("rst_flag", {31'h0, confirm_flag}, 32'h0);
        check("rst_rdata", {24'h0, io_rdata}, 32'h0);
        check("rst_index", {29'h0, test_index}, 32'h0);
        check("rst_led", {16'h0, led_out}, 32'h0);
        sb_q.push_back('{8'hA5, 3'd2});
        tick();
        rst = 1'b0;
        wait_flag(n);
        check_latency("reset_release_latency", n);

        // Read in strobe cycle returns pre-clear data; flag clears next cycle
        tick();
        io_read = 1'b1;
        sel     = SEL_DATA;
        @(negedge clk);
        check("strobe_rdata", {24'h0, io_rdata}, 32'hA5);
        check("strobe_flag", {31'h0, confirm_flag}, 32'h1);
        tick();
        io_read = 1'b0;
        @(negedge clk);
        check("clear_flag", {31'h0, confirm_flag}, 32'h0);
        check("sb_empty_reset", sb_q.size(), 32'h0);
        confirm_btn = 1'b0;
        ticks(2 + DEB + 4);

        // Clean press held for 20 cycles, reads against the pending flag
        switch_in   = 8'h3C;
        index_sw    = 3'd5;
        sb_q.push_back('{8'h3C, 3'd5});
        confirm_btn = 1'b1;
        wait_flag(n);
        check_latency("press_latency", n);
        for (int k = 0; k < 3; k++) begin
            tick();
            io_read = 1'b1;
            sel     = rv[k].s;
            tick();
            io_read = 1'b0;
            @(negedge clk);
            check($sformatf("read_sel%0d_flag", rv[k].s), {31'h0, confirm_flag}, {31'h0, rv[k].exp_flag});
        end
        check("consume_rdata", {24'h0, io_rdata}, 32'h3C);
        check("consume_index", {29'h0, test_index}, 32'h5);
        ticks(8);
        @(negedge clk);
        check("single_accept", {31'h0, confirm_flag}, 32'h0);
        tick();
        confirm_btn = 1'b0;
        ticks(2 + DEB + 6);
        check("sb_empty_press", sb_q.size(), 32'h0);

        // Bounce: 1-cycle pulses must not be accepted
        switch_in   = 8'h77;
        index_sw    = 3'd3;
        confirm_btn = 1'b1;
        tick();
        confirm_btn = 1'b0;
        tick();
        confirm_btn = 1'b1;
        tick();
        confirm_btn = 1'b0;
        ticks(15);
        @(negedge clk);
        check("bounce_flag", {31'h0, confirm_flag}, 32'h0);
        check("bounce_rdata", {24'h0, io_rdata}, 32'h3C);
        check("bounce_index", {29'h0, test_index}, 32'h5);

        // Simultaneous: accept lands while a SEL_DATA_ALT read is active
        tick();
        switch_in   = 8'h3C;
        index_sw    = 3'd5;
        sb_q.push_back('{8'h3C, 3'd5});
        confirm_btn = 1'b1;
        wait_flag(n);
        confirm_btn = 1'b0;
        ticks(2 + DEB + 4);
        switch_in   = 8'h81;
        index_sw    = 3'd1;
        sb_q.push_back('{8'h81, 3'd1});
        io_read     = 1'b1;
        sel         = SEL_DATA_ALT;
        confirm_btn = 1'b1;
        ticks(2 + DEB + 6);
        io_read = 1'b0;
        @(negedge clk);
        check("simul_flag_cleared_after", {31'h0, confirm_flag}, 32'h0);
        check("simul_rdata", {24'h0, io_rdata}, 32'h81);
        check("sb_empty_simul", sb_q.size(), 32'h0);
        tick();
        confirm_btn = 1'b0;
        ticks(2 + DEB + 4);

        // LED write vectors
        prev_led = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            tick();
            io_write = lv[k].wr;
            led_ctrl = lv[k].cs;
            sel      = lv[k].s;
            wdata    = lv[k].wd;
            @(negedge clk);
            check($sformatf("led_pre_%0d", k), {16'h0, led_out}, {16'h0, prev_led});
            tick();
            io_write = 1'b0;
            led_ctrl = 1'b0;
            @(negedge clk);
            check($sformatf("led_post_%0d", k), {16'h0, led_out}, {16'h0, lv[k].exp_led});
            prev_led = lv[k].exp_led;
        end

        // Reset mid-debounce, button still held at release
        tick();
        switch_in   = 8'hF0;
        index_sw    = 3'd6;
        confirm_btn = 1'b1;
        ticks(4);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_led", {16'h0, led_out}, 32'h0);
        check("midrst_rdata", {24'h0, io_rdata}, 32'h0);
        check("midrst_flag", {31'h0, confirm_flag}, 32'h0);
        ticks(3);
        sb_q.push_back('{8'hF0, 3'd6});
        rst = 1'b0;
        wait_flag(n);
        check_latency("midrst_latency", n);
        tick();
        confirm_btn = 1'b0;
        ticks(2 + DEB + 4);
        check("sb_empty_final", sb_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
